shift_result_buf: RTL and testbench

- Registered output stage directly downstream of the combinational 8-bit shifter.
- Each accepted cycle selects either the left-shift or right-shift result and buffers it with its direction tag in a small first-word-fall-through FIFO.
- The FIFO presents results to the consumer over a valid/ready handshake.
- Decouples the shifter's combinational path from downstream backpressure and counts consumer stall cycles.

---
 rtl/shift_result_buf.sv | 118 +++++++++++
 tb/tb_shift_result_buf.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_result_buf.sv
// shift_result_buf
// Registered output stage for the combinational 8-bit shifter. Each accepted
// cycle stores either the left- or right-shift result, together with a
// direction tag, in a small first-word-fall-through FIFO. The consumer reads
// over a valid/ready handshake. Cycles where the head is offered but not taken
// are counted in a saturating stall counter.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream presents a shift result pair
//   in_ready   buffer can accept this cycle (registered state only)
//   shl_in     left-shift result
//   shr_in     right-shift result
//   dir_sel    0 = store shl_in, 1 = store shr_in
//   out_valid  head entry valid
//   out_ready  consumer accepts head
//   data_out   head entry data
//   out_dir    head entry direction tag
//   zero_flag  head data is all zeros (0 whenever empty)
//   count      current occupancy
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0

module shift_result_buf #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int STALL_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         shl_in,
   input  logic [WIDTH-1:0]         shr_in,
   input  logic                     dir_sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         data_out,
   output logic                     out_dir,
   output logic                     zero_flag,
   output logic [$clog2(DEPTH):0]   count,
   output logic [STALL_W-1:0]       stall_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_data [DEPTH];
   logic [DEPTH-1:0] mem_dir;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   // Handshake qualifiers come only from registered occupancy, so a full
   // buffer refuses a push even if the head is popped in the same cycle.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // First-word-fall-through: the head entry is presented straight from storage.
   assign data_out  = mem_data[rd_ptr];
   assign out_dir   = mem_dir[rd_ptr];
   assign zero_flag = out_valid && (data_out == '0);

   // Storage write port; entries are cleared on reset so stale reads are zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
         end
         mem_dir <= '0;
      end else if (push) begin
         mem_data[wr_ptr] <= dir_sel ? shr_in : shl_in;
         mem_dir[wr_ptr]  <= dir_sel;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy; simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Stall counter saturates at all-ones and is cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {STALL_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_result_buf.sv
// tb_shift_result_buf
// Self-checking bench for shift_result_buf. A queue-based reference model
// tracks the buffered {dir, data} entries and the stall counters. A second
// instance with STALL_W=4 shares all inputs to observe saturation.

module tb_shift_result_buf;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] shl_in;
   logic [WIDTH-1:0] shr_in;
   logic             dir_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic             out_dir;
   logic             zero_flag;
   logic [2:0]       count;
   logic [15:0]      stall_cnt;

   logic             s_in_ready;
   logic             s_out_valid;
   logic [WIDTH-1:0] s_data_out;
   logic             s_out_dir;
   logic             s_zero_flag;
   logic [2:0]       s_count;
   logic [3:0]       s_stall_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference model: FIFO contents as {dir, data}, plus stall counters.
   logic [WIDTH:0] q[$];
   int unsigned    m_stall;
   int unsigned    m_stall_small;

   shift_result_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .shl_in(shl_in), .shr_in(shr_in), .dir_sel(dir_sel),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .out_dir(out_dir), .zero_flag(zero_flag), .count(count),
      .stall_cnt(stall_cnt)
   );

   shift_result_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .shl_in(shl_in), .shr_in(shr_in), .dir_sel(dir_sel),
      .out_valid(s_out_valid), .out_ready(out_ready), .data_out(s_data_out),
      .out_dir(s_out_dir), .zero_flag(s_zero_flag), .count(s_count),
      .stall_cnt(s_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock, updating the model from the pre-edge inputs and state,
   // then settle 1ns past the edge where outputs are sampled.
   task automatic step();
      bit push, pop, stall;
      @(posedge clk);
      push  = in_valid && (q.size() < DEPTH);
      pop   = (q.size() > 0) && out_ready;
      stall = (q.size() > 0) && !out_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back({dir_sel, dir_sel ? shr_in : shl_in});
      if (stall && m_stall < 65535) m_stall++;
      if (stall && m_stall_small < 15) m_stall_small++;
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      shl_in    = '0;
      shr_in    = '0;
      dir_sel   = 1'b0;
      rst_n     = 1'b0;
      #3;
      q.delete();
      m_stall       = 0;
      m_stall_small = 0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic push_val(input logic [WIDTH-1:0] v);
      in_valid = 1'b1;
      shl_in   = v;
      shr_in   = ~v;
      dir_sel  = 1'b0;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      out_ready = 1'b0;
      push_val(8'hA1);
      push_val(8'hA2);
      push_val(8'hA3);
      checks++;
      if (count !== 3'd3) begin
         failures++;
         $display("[TB] FAIL reset_prefill count got=%0d exp=3", count);
      end
      // Assert reset mid-cycle; outputs must clear without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || data_out !== 8'h00 ||
          stall_cnt !== 16'd0 || zero_flag !== 1'b0 || out_dir !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_async got v=%b cnt=%0d d=%h stall=%0d z=%b dir=%b exp 0/0/00/0/0/0",
                  out_valid, count, data_out, stall_cnt, zero_flag, out_dir);
      end
      #2;
      q.delete();
      m_stall       = 0;
      m_stall_small = 0;
      rst_n = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_select_tag();
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      shl_in = 8'h50; shr_in = 8'h05; dir_sel = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sel_no_bypass got out_valid=%b exp 0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || data_out !== 8'h50 || out_dir !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sel_shl got v=%b d=%h dir=%b exp 1/50/0", out_valid, data_out, out_dir);
      end
      shl_in = 8'h80; shr_in = 8'h01; dir_sel = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || data_out !== 8'h01 || out_dir !== 1'b1) begin
         failures++;
         $display("[TB] FAIL sel_shr got v=%b d=%h dir=%b exp 1/01/1", out_valid, data_out, out_dir);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         failures++;
         $display("[TB] FAIL sel_drain got v=%b cnt=%0d exp 0/0", out_valid, count);
      end
   endtask

   task automatic test_fill_full();
      logic [WIDTH-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_val(vals[i]);
      checks++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL full_state got cnt=%0d in_ready=%b exp 4/0", count, in_ready);
      end
      push_val(8'h55);
      checks++;
      if (count !== 3'd4 || data_out !== 8'h11) begin
         failures++;
         $display("[TB] FAIL full_reject got cnt=%0d d=%h exp 4/11", count, data_out);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || data_out !== vals[i]) begin
            failures++;
            $display("[TB] FAIL full_order[%0d] got v=%b d=%h exp 1/%h", i, out_valid, data_out, vals[i]);
         end
         step();
         if (i == 0) begin
            checks++;
            if (in_ready !== 1'b1) begin
               failures++;
               $display("[TB] FAIL full_ready_return got in_ready=%b exp 1", in_ready);
            end
         end
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL full_empty got out_valid=%b exp 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] heads [6] = '{8'hA1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      do_reset();
      out_ready = 1'b0;
      push_val(8'hA0);
      push_val(8'hA1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         shl_in = 8'(i + 1);
         step();
         checks++;
         if (count !== 3'd2 || data_out !== heads[i]) begin
            failures++;
            $display("[TB] FAIL b2b[%0d] got cnt=%0d d=%h exp 2/%h", i, count, data_out, heads[i]);
         end
      end
      in_valid = 1'b0;
      step();
      step();
      checks++;
      if (count !== 3'd0) begin
         failures++;
         $display("[TB] FAIL b2b_drain got cnt=%0d exp 0", count);
      end
   endtask

   task automatic test_zero_flag();
      do_reset();
      checks++;
      if (zero_flag !== 1'b0) begin
         failures++;
         $display("[TB] FAIL zero_empty got z=%b exp 0", zero_flag);
      end
      out_ready = 1'b0;
      push_val(8'h00);
      checks++;
      if (out_valid !== 1'b1 || zero_flag !== 1'b1) begin
         failures++;
         $display("[TB] FAIL zero_head got v=%b z=%b exp 1/1", out_valid, zero_flag);
      end
      in_valid = 1'b1; shl_in = 8'h00; shr_in = 8'h3C; dir_sel = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (zero_flag !== 1'b0 || data_out !== 8'h3C) begin
         failures++;
         $display("[TB] FAIL zero_nonzero got z=%b d=%h exp 0/3c", zero_flag, data_out);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || zero_flag !== 1'b0) begin
         failures++;
         $display("[TB] FAIL zero_drained got v=%b z=%b exp 0/0", out_valid, zero_flag);
      end
   endtask

   task automatic test_stall();
      do_reset();
      out_ready = 1'b0;
      push_val(8'h77);
      repeat (10) step();
      checks++;
      if (stall_cnt !== 16'd10 || s_stall_cnt !== 4'd10) begin
         failures++;
         $display("[TB] FAIL stall_10 got %0d/%0d exp 10/10", stall_cnt, s_stall_cnt);
      end
      checks++;
      if (data_out !== 8'h77 || out_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL stall_hold got v=%b d=%h exp 1/77", out_valid, data_out);
      end
      repeat (10) step();
      checks++;
      if (stall_cnt !== 16'd20 || s_stall_cnt !== 4'd15) begin
         failures++;
         $display("[TB] FAIL stall_sat got %0d/%0d exp 20/15", stall_cnt, s_stall_cnt);
      end
      out_ready = 1'b1;
      step();
      step();
      checks++;
      if (stall_cnt !== 16'd20 || count !== 3'd0) begin
         failures++;
         $display("[TB] FAIL stall_stop got stall=%0d cnt=%0d exp 20/0", stall_cnt, count);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      logic [WIDTH:0] head;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         shl_in    = 8'($urandom);
         shr_in    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         dir_sel   = 1'($urandom);
         step();
         head = (q.size() > 0) ? q[0] : '0;
         checks++;
         if (count !== 3'(q.size()) || in_ready !== (q.size() < DEPTH) ||
             out_valid !== (q.size() > 0) || stall_cnt !== 16'(m_stall) ||
             s_stall_cnt !== 4'(m_stall_small) ||
             zero_flag !== ((q.size() > 0) && (head[WIDTH-1:0] == 0)) ||
             ((q.size() > 0) && ({out_dir, data_out} !== head))) begin
            failures++;
            errs++;
            if (errs <= 5)
               $display("[TB] FAIL random[%0d] got cnt=%0d rdy=%b v=%b d=%h dir=%b z=%b st=%0d exp cnt=%0d head=%h st=%0d",
                        i, count, in_ready, out_valid, data_out, out_dir, zero_flag, stall_cnt,
                        q.size(), head, m_stall);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      shl_in = '0; shr_in = '0; dir_sel = 1'b0;
      test_reset();
      test_select_tag();
      test_fill_full();
      test_back_to_back();
      test_zero_flag();
      test_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
